// File: rtl/wishbone_master_bridge.sv
// rtl/wishbone_master_bridge.sv - enable/busy request port to single Wishbone classic master cycles
// Optional bus timeout enabled by defining WISHBONE_MASTER_TIMEOUT_EN.
module wishbone_master_bridge #(
    parameter logic [3:0]  ADDRESS_PREFIX = 4'h3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] wbAddress,
    input  logic [3:0]  wbByteSelect,
    input  logic        wbEnable,
    input  logic        wbWriteEnable,
    input  logic [31:0] wbDataWrite,
    output logic [31:0] wbDataRead,
    output logic        wbBusy,
    output logic        wbError,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        cyc_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        tmo_hit;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef WISHBONE_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q;

    // Hit during the Nth BUS cycle so cyc is high for exactly TIMEOUT_CYCLES cycles.
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 8'd0;
        end else if (state_q == S_IDLE) begin
            tmo_q <= 8'd0;
        end else if (state_q == S_BUS && tmo_q != 8'hFF) begin
            tmo_q <= tmo_q + 8'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            rdata_q <= 32'hFFFF_FFFF;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wbEnable) begin
                        cyc_q   <= 1'b1;
                        we_q    <= wbWriteEnable;
                        sel_q   <= wbByteSelect;
                        adr_q   <= {ADDRESS_PREFIX, wbAddress & 28'hFFF_FFFC};
                        dat_q   <= wbDataWrite;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    // err outranks ack; timeout only applies when the slave stays silent
                    if (wb_err_i) begin
                        rdata_q <= 32'hFFFF_FFFF;
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_RESP;
                    end else if (wb_ack_i) begin
                        if (!we_q) begin
                            rdata_q <= wb_data_i;
                        end
                        err_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_RESP;
                    end else if (tmo_hit) begin
                        rdata_q <= 32'hFFFF_FFFF;
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbBusy     = (state_q != S_RESP);
    assign wbDataRead = rdata_q;
    assign wbError    = err_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = sel_q;
    assign wb_adr_o   = adr_q;
    assign wb_data_o  = dat_q;

endmodule

// File: tb/tb_wishbone_master_bridge.sv
// tb/tb_wishbone_master_bridge.sv - scoreboard bench for wishbone_master_bridge
// Build with WISHBONE_MASTER_TIMEOUT_EN to exercise the timeout path.
module tb_wishbone_master_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] wbAddress = '0;
    logic [3:0]  wbByteSelect = '0;
    logic        wbEnable = 1'b0;
    logic        wbWriteEnable = 1'b0;
    logic [31:0] wbDataWrite = '0;
    logic [31:0] wbDataRead;
    logic        wbBusy;
    logic        wbError;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    always #5 clk = ~clk;

    wishbone_master_bridge #(
        .ADDRESS_PREFIX(4'h3),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wbAddress(wbAddress),
        .wbByteSelect(wbByteSelect),
        .wbEnable(wbEnable),
        .wbWriteEnable(wbWriteEnable),
        .wbDataWrite(wbDataWrite),
        .wbDataRead(wbDataRead),
        .wbBusy(wbBusy),
        .wbError(wbError),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o),
        .wb_data_o(wb_data_o),
        .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          len;
    } bus_t;

    // kind: 0 ack, 1 err, 2 err+ack, 3 silent slave
    typedef struct {
        int          waits;
        int          kind;
        logic [31:0] rdata;
    } slv_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    slv_t slv_q[$];
    rsp_t rsp_q[$];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'hFFFF_FFFF;
    bit          prev_held = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_expect(input logic we, input logic [27:0] a, input logic [3:0] s,
                               input logic [31:0] d, input int waits, input int kind,
                               input logic [31:0] rdata, input bit want_rsp);
        bus_t b;
        slv_t sv;
        rsp_t r;
        b.adr = {4'h3, a[27:2], 2'b00};
        b.sel = s;
        b.we  = we;
        b.dat = d;
        b.len = waits + 1;
        sv.waits = waits;
        sv.kind  = kind;
        sv.rdata = rdata;
        bus_q.push_back(b);
        slv_q.push_back(sv);
        if (want_rsp) begin
            if (kind == 0) begin
                if (!we) model_rdata = rdata;
                r.err = 1'b0;
            end else begin
                model_rdata = 32'hFFFF_FFFF;
                r.err = 1'b1;
            end
            r.rdata = model_rdata;
            rsp_q.push_back(r);
        end
    endtask

    task automatic drive_req(input logic we, input logic [27:0] a, input logic [3:0] s,
                             input logic [31:0] d);
        wbEnable      = 1'b1;
        wbWriteEnable = we;
        wbAddress     = a;
        wbByteSelect  = s;
        wbDataWrite   = d;
    endtask

    // Called at a negedge; returns at a negedge where the bridge is IDLE (or RESP when hold=1).
    task automatic txn(input logic we, input logic [27:0] a, input logic [3:0] s,
                       input logic [31:0] d, input int waits, input int kind,
                       input logic [31:0] rdata, input bit hold);
        int k;
        bit seen;
        push_expect(we, a, s, d, waits, kind, rdata, 1'b1);
        drive_req(we, a, s, d);
        k = 1;
        seen = 1'b0;
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            if (!wbBusy) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_resp: got no response within %0d cycles required one", k);
        end else begin
            check("latency", k, waits + 3 + (prev_held ? 1 : 0));
        end
        prev_held = hold;
        if (!hold) begin
            wbEnable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_busy", wbBusy, 1'b1);
        wbEnable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 32'hFFFF_FFFF;
        prev_held = 1'b0;
        @(negedge clk);
    endtask

    // Wishbone slave model
    initial begin
        slv_t cur;
        int   cnt;
        bit   active;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = '0;
        cur.waits = -1;
        cur.kind  = 3;
        cur.rdata = '0;
        cnt = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            wb_ack_i  = 1'b0;
            wb_err_i  = 1'b0;
            wb_data_i = $urandom;
            if (!rst_n) begin
                active = 1'b0;
            end else if (wb_cyc_o) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (slv_q.size() > 0) begin
                        cur = slv_q.pop_front();
                    end else begin
                        cur.waits = -1;
                        cur.kind  = 3;
                    end
                end
                if (cnt == cur.waits) begin
                    wb_data_i = cur.rdata;
                    case (cur.kind)
                        0: wb_ack_i = 1'b1;
                        1: wb_err_i = 1'b1;
                        2: begin
                            wb_ack_i = 1'b1;
                            wb_err_i = 1'b1;
                        end
                        default: ;
                    endcase
                end
                cnt++;
            end else begin
                active = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && !wbBusy) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got response with rdata %h required none", wbDataRead);
                end else begin
                    r = rsp_q.pop_front();
                    check("rdata", wbDataRead, r.rdata);
                    check("error", wbError, r.err);
                end
            end
        end
    end

    // Bus monitor
    initial begin
        bus_t cb;
        bit   cb_valid;
        bit   cyc_prev;
        int   blen;
        cb_valid = 1'b0;
        cyc_prev = 1'b0;
        blen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc_prev = 1'b0;
                cb_valid = 1'b0;
                blen = 0;
            end else begin
                if (wb_cyc_o && !cyc_prev) begin
                    blen = 0;
                    if (bus_q.size() == 0) begin
                        cb_valid = 1'b0;
                        n_tests++;
                        n_fail++;
                        $display("FAIL dup_access: got bus cycle adr %h required none", wb_adr_o);
                    end else begin
                        cb = bus_q.pop_front();
                        cb_valid = 1'b1;
                        check("adr", wb_adr_o, cb.adr);
                        check("sel", wb_sel_o, cb.sel);
                        check("we", wb_we_o, cb.we);
                        check("data_o", wb_data_o, cb.dat);
                        check("stb", wb_stb_o, 1'b1);
                    end
                end
                if (wb_cyc_o) blen++;
                if (!wb_cyc_o && cyc_prev && cb_valid) begin
                    check("cyc_len", blen, cb.len);
                    check("we_drop", wb_we_o, 1'b0);
                end
                cyc_prev = wb_cyc_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int kind;
        repeat (3) @(negedge clk);
        check("reset_cyc", wb_cyc_o, 1'b0);
        check("reset_stb", wb_stb_o, 1'b0);
        check("reset_we", wb_we_o, 1'b0);
        check("reset_sel", wb_sel_o, 4'h0);
        check("reset_adr", wb_adr_o, 32'h0);
        check("reset_data_o", wb_data_o, 32'h0);
        check("reset_rdata", wbDataRead, 32'hFFFF_FFFF);
        check("reset_busy", wbBusy, 1'b1);
        check("reset_error", wbError, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 28'h000_1234, 4'hF, 32'h0, 2, 0, 32'hDEAD_BEEF, 1'b0);
        txn(1'b1, 28'h000_0010, 4'b0011, 32'h1122_3344, 0, 0, 32'h5555_AAAA, 1'b0);
        txn(1'b0, 28'($urandom), 4'hF, 32'h0, 1, 2, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 28'($urandom), 4'($urandom), 32'($urandom), $urandom_range(0, 2), 0,
                32'($urandom), i < 3);
        end

`ifdef WISHBONE_MASTER_TIMEOUT_EN
        txn(1'b0, 28'($urandom), 4'hF, 32'h0, TMO - 1, 3, 32'h0, 1'b0);
`else
        push_expect(1'b0, 28'h0AB_CDE0, 4'hF, 32'h0, -1, 3, 32'h0, 1'b0);
        drive_req(1'b0, 28'h0AB_CDE0, 4'hF, 32'h0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wbBusy) cnt++;
        end
        check("no_timeout_cyc", cnt, 1000);
        reset_pulse();
`endif
        txn(1'b1, 28'($urandom), 4'hC, 32'($urandom), 1, 0, 32'h0, 1'b0);

        push_expect(1'b0, 28'h123_4560, 4'hF, 32'h0, 20, 0, 32'h0, 1'b0);
        drive_req(1'b0, 28'h123_4560, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        reset_pulse();
        txn(1'b0, 28'h000_0040, 4'hF, 32'h0, 1, 0, 32'hCAFE_F00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 7) ? 0 : ((kind < 9) ? 1 : 2);
            txn(1'($urandom), 28'($urandom), 4'($urandom), 32'($urandom),
                $urandom_range(0, 4), kind, 32'($urandom), (i < 39) ? 1'($urandom) : 1'b0);
        end

        repeat (5) @(negedge clk);
        check("rsp_q_drained", rsp_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
